// File: rtl/seg_scan_if.sv
// Signal bundle between the scan controller and its digit mux / display pins.
// master is the controller side; slave is the mux/board side.
interface seg_scan_if;
  logic       enable;
  logic [7:0] digit_mask;
  logic [7:0] dp_mask;
  logic [3:0] digit_in;
  logic [2:0] sel;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_tick;

  modport master (
    input  enable, digit_mask, dp_mask, digit_in,
    output sel, an_n, seg_n, dp_n, frame_tick
  );

  modport slave (
    output enable, digit_mask, dp_mask, digit_in,
    input  sel, an_n, seg_n, dp_n, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with blanking dead-time between digits.
// Every output is registered; the anode pattern is derived from the next state.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned BLANK_TICKS = 1000,
  parameter int unsigned SHOW_TICKS  = 99000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.master bus
);

  localparam int unsigned MaxTicks = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_TICKS - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_TICKS - 1);
  localparam logic [2:0]      SelLast   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            dp_n_q, dp_n_d;
  logic            ft_q, ft_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ft_d    = 1'b0;

    if (!bus.enable) begin
      state_d = StIdle;
      sel_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StBlank;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (sel_q == SelLast) begin
              sel_d = 3'd0;
              ft_d  = 1'b1;
            end else begin
              sel_d = sel_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end

    // Look ahead at the next state so the registered anodes line up with state_q.
    an_n_d = 8'hFF;
    dp_n_d = 1'b1;
    if (state_d == StShow) begin
      if (bus.digit_mask[sel_d]) begin
        an_n_d[sel_d] = 1'b0;
      end
      dp_n_d = ~bus.dp_mask[sel_d];
    end
  end

  // Full-hex decode, {g,f,e,d,c,b,a} active-low.
  always_comb begin
    seg_n_d = 7'h7F;
    case (bus.digit_in)
      4'h0:    seg_n_d = 7'b1000000;
      4'h1:    seg_n_d = 7'b1111001;
      4'h2:    seg_n_d = 7'b0100100;
      4'h3:    seg_n_d = 7'b0110000;
      4'h4:    seg_n_d = 7'b0011001;
      4'h5:    seg_n_d = 7'b0010010;
      4'h6:    seg_n_d = 7'b0000010;
      4'h7:    seg_n_d = 7'b1111000;
      4'h8:    seg_n_d = 7'b0000000;
      4'h9:    seg_n_d = 7'b0010000;
      4'hA:    seg_n_d = 7'b0001000;
      4'hB:    seg_n_d = 7'b0000011;
      4'hC:    seg_n_d = 7'b1000110;
      4'hD:    seg_n_d = 7'b0100001;
      4'hE:    seg_n_d = 7'b0000110;
      4'hF:    seg_n_d = 7'b0001110;
      default: seg_n_d = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      an_n_q  <= 8'hFF;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      ft_q    <= ft_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an_n       = an_n_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with BLANK=2, SHOW=4, 8 digits (48-cycle frame).
// The mux model returns sel plus an offset so the upper hex codes get decoded too.
module tb_seg_scan_ctrl;

  localparam int FrameLen = 48;
  localparam int SlotLen  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] off = 4'd0;
  logic [7:0] dmask = 8'hFF;
  logic [7:0] pmask = 8'h00;

  int n_vec  = 0;
  int n_err  = 0;
  int pos    = 0;
  int frames = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_if bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .BLANK_TICKS (2),
    .SHOW_TICKS  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.digit_in   = {1'b0, bus.sel} + off;
  assign bus.digit_mask = dmask;
  assign bus.dp_mask    = pmask;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(bus.an_n), 32'h0FF);
    chk({tag, "_sel"}, 32'(bus.sel), 32'h0);
    chk({tag, "_dp"}, 32'(bus.dp_n), 32'h1);
    chk({tag, "_ft"}, 32'(bus.frame_tick), 32'h0);
  endtask

  // Samples n cycles at the falling edge; pos is the frame position of each sample.
  task automatic scan(input string tag, input int n);
    int         slot;
    int         ph;
    bit         show;
    logic [7:0] exp_an;
    logic       exp_dp;
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      slot   = pos / SlotLen;
      ph     = pos % SlotLen;
      show   = (ph >= 2);
      exp_an = 8'hFF;
      exp_dp = 1'b1;
      if (show) begin
        if (dmask[slot]) exp_an[slot] = 1'b0;
        exp_dp = ~pmask[slot];
      end
      chk({tag, "_an"}, 32'(bus.an_n), 32'(exp_an));
      chk({tag, "_sel"}, 32'(bus.sel), 32'(slot));
      chk({tag, "_dp"}, 32'(bus.dp_n), 32'(exp_dp));
      chk({tag, "_ft"}, 32'(bus.frame_tick), 32'((pos == 0) && (frames > 0)));
      if (show) begin
        d = 4'(slot) + off;
        chk({tag, "_seg"}, 32'(bus.seg_n), 32'(seg_tab[d]));
      end
      pos++;
      if (pos == FrameLen) begin
        pos = 0;
        frames++;
      end
    end
  endtask

  initial begin
    bus.enable = 1'b1;

    // Reset with enable high; outputs must clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_dark("reset");
    chk("reset_seg", 32'(bus.seg_n), 32'h7F);

    @(negedge clk);
    rst    = 1'b0;
    pos    = 0;
    frames = 0;

    // Two full frames plus the start of a third, all digits lit.
    scan("full", 2 * FrameLen + 1);

    // Sparse digit and decimal-point masks; frame_tick must still arrive every 48.
    dmask = 8'b0000_0101;
    pmask = 8'h04;
    scan("mask", FrameLen);

    // Shift the mux so digits 8..F are decoded; mixed decimal points.
    dmask = 8'hFF;
    pmask = 8'hA5;
    off   = 4'd8;
    scan("hex", FrameLen);

    // Drop enable in the middle of digit 3 SHOW.
    off   = 4'd0;
    pmask = 8'h00;
    scan("pre_dis", 21);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_dark("disabled");
    end
    bus.enable = 1'b1;
    pos    = 0;
    frames = 0;
    scan("reenable", 14);

    // Async reset in the middle of digit 5 SHOW.
    scan("pre_rst", 20);
    #1 rst = 1'b1;
    #1;
    chk_dark("midrst");
    chk("midrst_seg", 32'(bus.seg_n), 32'h7F);
    @(negedge clk);
    rst    = 1'b0;
    pos    = 0;
    frames = 0;
    scan("post_rst", 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
